// File: rtl/key_debounce_pkg.sv
// ============================================================================
//  Module   : key_pkg
//  Purpose  : Shared types and constants for the key debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

   // Per-channel filter state: stable or pending in each direction.
   typedef enum logic [1:0] {
      UP      = 2'd0,
      DN_PEND = 2'd1,
      DN      = 2'd2,
      UP_PEND = 2'd3
   } key_st_t;

   // Default filter length: 20 ms of stability at a 50 MHz clock.
   localparam int KEY_DEB_CYCLES_50MHZ_20MS = 1_000_000;

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_debounce_if.sv
// ============================================================================
//  Module   : key_debounce_if
//  Purpose  : Key pins in, debounced level and press/release pulses out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_debounce_if #(
   parameter int NUM_KEYS = 2
);
   logic [NUM_KEYS-1:0] key_raw;       // raw active-low pins
   logic [NUM_KEYS-1:0] key_level;     // debounced level, 0 = pressed
   logic [NUM_KEYS-1:0] key_press;     // one-cycle pulse on accepted press
   logic [NUM_KEYS-1:0] key_release;   // one-cycle pulse on accepted release

   // Board / stimulus side: drives the pins, observes the filtered result.
   modport master (
      output key_raw,
      input  key_level,
      input  key_press,
      input  key_release
   );

   // Debouncer side.
   modport slave (
      input  key_raw,
      output key_level,
      output key_press,
      output key_release
   );
endinterface : key_debounce_if

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
//  Module   : key_debounce_ch
//  Purpose  : One key channel: 2-flop synchroniser, stability counter FSM,
//             registered level and press/release pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEB_CYCLES = KEY_DEB_CYCLES_50MHZ_20MS
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  i_key_raw,
   output logic o_key_level,
   output logic o_key_press,
   output logic o_key_release
);

   // Counter only ever reaches DEB_CYCLES-1, so clog2 bits are enough.
   localparam int               CNT_W      = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

   logic             r_s1;
   logic             r_s2;
   key_st_t          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   // Bring the asynchronous pin into the clk domain; idle (released) is 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= i_key_raw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after DEB_CYCLES consecutive matching samples;
   // any reversion drops back to the stable state with the count cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= UP;
         r_cnt     <= C_CNT_ZERO;
         r_level   <= 1'b1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            UP: begin
               if (!r_s2) begin
                  r_state <= DN_PEND;
                  r_cnt   <= C_CNT_ONE;
               end
            end
            DN_PEND: begin
               if (r_s2) begin
                  r_state <= UP;
                  r_cnt   <= C_CNT_ZERO;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state <= DN;
                  r_cnt   <= C_CNT_ZERO;
                  r_level <= 1'b0;
                  r_press <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
            DN: begin
               if (r_s2) begin
                  r_state <= UP_PEND;
                  r_cnt   <= C_CNT_ONE;
               end
            end
            UP_PEND: begin
               if (!r_s2) begin
                  r_state <= DN;
                  r_cnt   <= C_CNT_ZERO;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state   <= UP;
                  r_cnt     <= C_CNT_ZERO;
                  r_level   <= 1'b1;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
            default: begin
               r_state <= UP;
               r_cnt   <= C_CNT_ZERO;
            end
         endcase
      end
   end

   assign o_key_level   = r_level;
   assign o_key_press   = r_press;
   assign o_key_release = r_release;

endmodule : key_debounce_ch

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module   : key_debounce
//  Purpose  : NUM_KEYS independent debounce channels behind one interface.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS   = 2,
   parameter int DEB_CYCLES = KEY_DEB_CYCLES_50MHZ_20MS
) (
   input wire             clk,
   input wire             rst_n,
   key_debounce_if.slave  bus
);

   logic [NUM_KEYS-1:0] w_level;
   logic [NUM_KEYS-1:0] w_press;
   logic [NUM_KEYS-1:0] w_release;

   // One self-contained channel per key; bit i of every port belongs to key i.
   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_key_raw     (bus.key_raw[g]),
         .o_key_level   (w_level[g]),
         .o_key_press   (w_press[g]),
         .o_key_release (w_release[g])
      );
   end

   assign bus.key_level   = w_level;
   assign bus.key_press   = w_press;
   assign bus.key_release = w_release;

endmodule : key_debounce

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
//  Module   : tb_key_debounce
//  Purpose  : Scoreboard bench for key_debounce (NUM_KEYS=2, DEB_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

   localparam int NK  = 2;
   localparam int DEB = 8;

   logic clk;
   logic rst_n;

   key_debounce_if #(.NUM_KEYS(NK)) bus ();

   key_debounce #(
      .NUM_KEYS   (NK),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {level, press, release} after each rising edge.
   logic [3*NK-1:0] q_exp[$];

   int n_cmp;
   int n_err;
   int n_exp_press;
   int n_obs_press;
   int cyc;

   // Reference: ideal 2-cycle delay of the pin, then count how long the
   // delayed value has disagreed with the accepted level.
   logic m_sa  [NK];
   logic m_sb  [NK];
   logic m_lvl [NK];
   int   m_run [NK];

   function automatic void model_reset();
      for (int k = 0; k < NK; k++) begin
         m_sa[k]  = 1'b1;
         m_sb[k]  = 1'b1;
         m_lvl[k] = 1'b1;
         m_run[k] = 0;
      end
   endfunction

   function automatic logic [3*NK-1:0] model_edge(input logic [NK-1:0] raw);
      logic [NK-1:0] lv, pr, rl;
      lv = '0; pr = '0; rl = '0;
      for (int k = 0; k < NK; k++) begin
         if (m_sb[k] != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               m_lvl[k] = m_sb[k];
               m_run[k] = 0;
               if (m_lvl[k] == 1'b0) begin
                  pr[k] = 1'b1;
                  n_exp_press++;
               end else begin
                  rl[k] = 1'b1;
               end
            end
         end else begin
            m_run[k] = 0;
         end
         m_sb[k] = m_sa[k];
         m_sa[k] = raw[k];
         lv[k]   = m_lvl[k];
      end
      return {lv, pr, rl};
   endfunction

   // One clock of stimulus: change inputs just after the falling edge,
   // then predict the state after the following rising edge.
   task automatic step(input logic [NK-1:0] raw, input logic rst_v);
      @(negedge clk);
      #1;
      bus.key_raw = raw;
      rst_n       = rst_v;
      if (!rst_v) model_reset();
      @(posedge clk);
      if (!rst_v) q_exp.push_back({{NK{1'b1}}, {NK{1'b0}}, {NK{1'b0}}});
      else        q_exp.push_back(model_edge(raw));
   endtask

   task automatic hold(input logic [NK-1:0] raw, input int n, input logic rst_v);
      for (int i = 0; i < n; i++) step(raw, rst_v);
   endtask

   // Monitor: every falling edge the DUT presents a fresh output word.
   always @(negedge clk) begin
      logic [3*NK-1:0] exp_w;
      logic [3*NK-1:0] act_w;
      cyc++;
      if (q_exp.size() > 0) begin
         exp_w = q_exp.pop_front();
         act_w = {bus.key_level, bus.key_press, bus.key_release};
         n_obs_press += $countones(bus.key_press);
         n_cmp++;
         if (act_w !== exp_w) begin
            n_err++;
            $display("FAIL outputs cyc=%0d lvl/prs/rel actual=%b_%b_%b required=%b_%b_%b",
                     cyc, act_w[3*NK-1:2*NK], act_w[2*NK-1:NK], act_w[NK-1:0],
                     exp_w[3*NK-1:2*NK], exp_w[2*NK-1:NK], exp_w[NK-1:0]);
         end
      end
   end

   initial begin
      logic [NK-1:0] raw;
      n_cmp = 0; n_err = 0; n_exp_press = 0; n_obs_press = 0; cyc = 0;
      rst_n       = 1'b0;
      bus.key_raw = '1;
      model_reset();

      // Held through reset, then accepted 10 edges after release.
      hold(2'b00, 3, 1'b0);
      hold(2'b00, 12, 1'b1);
      hold(2'b11, 12, 1'b1);
      // Clean press on key 0 only.
      hold(2'b10, 12, 1'b1);
      hold(2'b11, 12, 1'b1);
      // Bounce: 5 low, 1 high, then low held.
      hold(2'b10, 5, 1'b1);
      hold(2'b11, 1, 1'b1);
      hold(2'b10, 12, 1'b1);
      hold(2'b11, 12, 1'b1);
      // Glitches of 1 and DEB-1 cycles.
      hold(2'b10, 1, 1'b1);
      hold(2'b11, 4, 1'b1);
      hold(2'b10, DEB - 1, 1'b1);
      hold(2'b11, 12, 1'b1);
      // Both pressed, then released together.
      hold(2'b00, 12, 1'b1);
      hold(2'b11, 12, 1'b1);
      // Reset in the middle of a pending press on key 1.
      hold(2'b01, 7, 1'b1);
      hold(2'b01, 2, 1'b0);
      hold(2'b01, 12, 1'b1);
      hold(2'b11, 12, 1'b1);

      // Random pins with runs around the filter length, occasional reset.
      raw = 2'b11;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NK; k++)
            if ($urandom_range(0, 10) == 0) raw[k] = ~raw[k];
         step(raw, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
      end
      hold(2'b11, 12, 1'b1);

      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL drain actual=%0d required=0", q_exp.size());
      end
      n_cmp++;
      if (n_obs_press != n_exp_press) begin
         n_err++;
         $display("FAIL press_count actual=%0d required=%0d", n_obs_press, n_exp_press);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_key_debounce

`default_nettype wire
